// File: rtl/router_fsm_pkg.sv
// Shared definitions for the 1x3 router packet-reception controller:
// state encodings, the never-routed header address, the port count and a
// small helper that picks one per-port flag by address.
package router_fsm_pkg;

   localparam int         NUM_PORTS        = 3;
   localparam logic [1:0] INVALID_ADDR_DEF = 2'b11;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_e;

   // Select the flag belonging to output port `addr`; the unrouted address
   // reads as 0 so it can never trigger a transition by itself.
   function automatic logic pick_port(input logic [NUM_PORTS-1:0] flags,
                                      input logic [1:0]           addr);
      logic bit_sel;
      case (addr)
         2'd0:    bit_sel = flags[0];
         2'd1:    bit_sel = flags[1];
         2'd2:    bit_sel = flags[2];
         default: bit_sel = 1'b0;
      endcase
      return bit_sel;
   endfunction

endpackage

// File: rtl/router_sat_counter.sv
// Saturating up-counter used for the router statistics.
// Counts one per cycle while inc is high and holds at all-ones.
module router_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on inc, stick at the maximum value.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/router_fsm.sv
// Packet-reception controller for the 1x3 router.
// Moore FSM sequencing header decode, payload and parity loading into the
// destination FIFO; all outputs decode from the registered state.
// Optional feature macro: ROUTER_FSM_STATS_EN adds saturating pkt_count and
// drop_count outputs (CNT_W bits each). FSM behaviour is the same either way.
module router_fsm
   import router_fsm_pkg::*;
#(
   parameter logic [1:0] INVALID_ADDR = INVALID_ADDR_DEF
`ifdef ROUTER_FSM_STATS_EN
   ,
   parameter int         CNT_W        = 8
`endif
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             pkt_valid,
   input  logic [1:0]       data_in,
   input  logic             fifo_full,
   input  logic             fifo_empty_0,
   input  logic             fifo_empty_1,
   input  logic             fifo_empty_2,
   input  logic             soft_reset_0,
   input  logic             soft_reset_1,
   input  logic             soft_reset_2,
   input  logic             parity_done,
   input  logic             low_pkt_valid,
   output logic             detect_add,
   output logic             lfd_state,
   output logic             ld_state,
   output logic             laf_state,
   output logic             full_state,
   output logic             rst_int_reg,
   output logic             write_enb_reg,
`ifdef ROUTER_FSM_STATS_EN
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] drop_count,
`endif
   output logic             busy
);

   state_e                 state;
   state_e                 next_state;
   logic [1:0]             addr_q;
   logic [NUM_PORTS-1:0]   empty_vec;
   logic [NUM_PORTS-1:0]   sreset_vec;
   logic                   sel_empty;
   logic                   sel_sreset;
   logic                   hdr_empty;
   logic                   hdr_valid;

   assign empty_vec  = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign sreset_vec = {soft_reset_2, soft_reset_1, soft_reset_0};
   assign sel_empty  = pick_port(empty_vec, addr_q);
   assign sel_sreset = pick_port(sreset_vec, addr_q);
   // The header decision looks at the live address, not the latched one.
   assign hdr_empty  = pick_port(empty_vec, data_in);
   assign hdr_valid  = pkt_valid && (data_in != INVALID_ADDR);

   // State register and latched destination address.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= DECODE_ADDRESS;
         addr_q <= 2'b00;
      end else begin
         state <= next_state;
         if ((state == DECODE_ADDRESS) && hdr_valid) begin
            addr_q <= data_in;
         end
      end
   end

   // Next-state logic; a soft reset of the selected FIFO overrides everything.
   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      if (sel_sreset) begin
         next_state = DECODE_ADDRESS;
      end else begin
         case (state)
            DECODE_ADDRESS: begin
               if (hdr_valid) begin
                  next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
               end
            end
            WAIT_TILL_EMPTY: begin
               if (sel_empty) next_state = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: begin
               next_state = LOAD_DATA;
            end
            LOAD_DATA: begin
               // Full wins over the parity byte; parity completes via LOAD_AFTER_FULL.
               if (fifo_full)       next_state = FIFO_FULL_STATE;
               else if (!pkt_valid) next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
               if (!fifo_full) next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
               if (parity_done)        next_state = DECODE_ADDRESS;
               else if (low_pkt_valid) next_state = LOAD_PARITY;
               else                    next_state = LOAD_DATA;
            end
            LOAD_PARITY: begin
               next_state = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
               next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: begin
               next_state = DECODE_ADDRESS;
            end
         endcase
      end
   end

   assign detect_add    = (state == DECODE_ADDRESS);
   assign lfd_state     = (state == LOAD_FIRST_DATA);
   assign ld_state      = (state == LOAD_DATA);
   assign laf_state     = (state == LOAD_AFTER_FULL);
   assign full_state    = (state == FIFO_FULL_STATE);
   assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
   assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) ||
                          (state == LOAD_PARITY);
   assign busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

`ifdef ROUTER_FSM_STATS_EN
   logic pkt_inc;
   logic drop_inc;

   // Completed packets are counted on entry to the parity check; drops are
   // unrouted headers plus packets aborted by a FIFO soft reset.
   assign pkt_inc  = (state != CHECK_PARITY_ERROR) && (next_state == CHECK_PARITY_ERROR);
   assign drop_inc = ((state == DECODE_ADDRESS) && pkt_valid && (data_in == INVALID_ADDR)) ||
                     (sel_sreset && (state != DECODE_ADDRESS));

   router_sat_counter #(.W(CNT_W)) u_pkt_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (pkt_inc),
      .count (pkt_count)
   );

   router_sat_counter #(.W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (drop_inc),
      .count (drop_count)
   );
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm.
// Outputs are packed as {detect_add, lfd, ld, laf, full, rst_int, wen, busy}
// and compared against hand-derived per-state patterns. Statistics checks
// run only when ROUTER_FSM_STATS_EN is defined.
module tb_router_fsm;

   localparam logic [7:0] S_DEC  = 8'b1000_0000;
   localparam logic [7:0] S_WAIT = 8'b0000_0001;
   localparam logic [7:0] S_LFD  = 8'b0100_0001;
   localparam logic [7:0] S_LD   = 8'b0010_0010;
   localparam logic [7:0] S_FULL = 8'b0000_1001;
   localparam logic [7:0] S_LAF  = 8'b0001_0011;
   localparam logic [7:0] S_LP   = 8'b0000_0011;
   localparam logic [7:0] S_CPE  = 8'b0000_0101;

   logic       clk = 1'b0;
   logic       rstn;
   logic       pkt_valid, fifo_full, parity_done, low_pkt_valid;
   logic [1:0] data_in;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       rst_int_reg, write_enb_reg, busy;
`ifdef ROUTER_FSM_STATS_EN
   logic [7:0] pkt_count, drop_count;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   router_fsm dut (
      .clk           (clk),
      .rstn          (rstn),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .fifo_empty_0  (fifo_empty_0),
      .fifo_empty_1  (fifo_empty_1),
      .fifo_empty_2  (fifo_empty_2),
      .soft_reset_0  (soft_reset_0),
      .soft_reset_1  (soft_reset_1),
      .soft_reset_2  (soft_reset_2),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .rst_int_reg   (rst_int_reg),
      .write_enb_reg (write_enb_reg),
`ifdef ROUTER_FSM_STATS_EN
      .pkt_count     (pkt_count),
      .drop_count    (drop_count),
`endif
      .busy          (busy)
   );

   function automatic logic [7:0] outs();
      return {detect_add, lfd_state, ld_state, laf_state, full_state,
              rst_int_reg, write_enb_reg, busy};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs changed after this return are seen next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Short good packet to addr with an empty FIFO and no back-pressure.
   task automatic send_pkt(input logic [1:0] addr);
      pkt_valid = 1'b1; data_in = addr;
      step();
      step();
      pkt_valid = 1'b0;
      step();
      step();
      step();
   endtask

   initial begin
      rstn = 1'b0; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
      parity_done = 1'b0; low_pkt_valid = 1'b0;
      fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
      step();
      step();
      check("reset_state", outs(), S_DEC);
`ifdef ROUTER_FSM_STATS_EN
      check("reset_pkt_count", pkt_count, 8'd0);
      check("reset_drop_count", drop_count, 8'd0);
`endif
      rstn = 1'b1;
      step();
      check("idle_decode", outs(), S_DEC);

      // Packet to addr 1, empty FIFO: LFD one cycle, then LD, parity, check.
      pkt_valid = 1'b1; data_in = 2'b01;
      step(); check("p1_lfd", outs(), S_LFD);
      step(); check("p1_ld", outs(), S_LD);
      step(); check("p1_ld_hold", outs(), S_LD);
      pkt_valid = 1'b0;
      step(); check("p1_lp", outs(), S_LP);
      step(); check("p1_cpe", outs(), S_CPE);
      step(); check("p1_dec", outs(), S_DEC);

      // Packet to addr 2 with non-empty FIFO: wait, then full/low_pkt_valid path.
      fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'b10;
      step(); check("p2_wait", outs(), S_WAIT);
      step(); check("p2_wait_hold", outs(), S_WAIT);
      fifo_empty_2 = 1'b1;
      step(); check("p2_lfd", outs(), S_LFD);
      step(); check("p2_ld", outs(), S_LD);
      fifo_full = 1'b1;
      step(); check("p2_full", outs(), S_FULL);
      step(); check("p2_full_hold", outs(), S_FULL);
      fifo_full = 1'b0;
      step(); check("p2_laf", outs(), S_LAF);
      low_pkt_valid = 1'b1;
      step(); check("p2_low_lp", outs(), S_LP);
      low_pkt_valid = 1'b0; pkt_valid = 1'b0;
      step(); check("p2_cpe", outs(), S_CPE);
      step(); check("p2_dec", outs(), S_DEC);

      // Packet to addr 1: after full, parity_done returns straight to decode.
      pkt_valid = 1'b1; data_in = 2'b01;
      step(); step(); check("p3_ld", outs(), S_LD);
      fifo_full = 1'b1;
      step(); check("p3_full", outs(), S_FULL);
      fifo_full = 1'b0;
      step(); check("p3_laf", outs(), S_LAF);
      parity_done = 1'b1; pkt_valid = 1'b0;
      step(); check("p3_pdone_dec", outs(), S_DEC);
      parity_done = 1'b0;

      // LAF with neither flag returns to LOAD_DATA.
      pkt_valid = 1'b1; data_in = 2'b00;
      step(); step();
      fifo_full = 1'b1;
      step();
      fifo_full = 1'b0;
      step(); check("p4_laf", outs(), S_LAF);
      step(); check("p4_laf_to_ld", outs(), S_LD);
      // Simultaneous full and pkt_valid drop: full wins.
      fifo_full = 1'b1; pkt_valid = 1'b0;
      step(); check("p4_full_wins", outs(), S_FULL);
      fifo_full = 1'b0;
      step(); check("p4_laf2", outs(), S_LAF);
      low_pkt_valid = 1'b1;
      step(); check("p4_lp", outs(), S_LP);
      low_pkt_valid = 1'b0; fifo_full = 1'b1;
      step(); check("p4_cpe", outs(), S_CPE);
      step(); check("p4_cpe_full", outs(), S_FULL);

      // Soft reset of an unrelated FIFO is ignored; selected one aborts.
      soft_reset_1 = 1'b1;
      step(); check("sreset_other", outs(), S_FULL);
      soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
      step(); check("sreset_sel", outs(), S_DEC);
      soft_reset_0 = 1'b0; fifo_full = 1'b0;

      // Same abort for addr 1 from FIFO_FULL_STATE; soft_reset_0 no effect.
      pkt_valid = 1'b1; data_in = 2'b01;
      step(); step();
      fifo_full = 1'b1; pkt_valid = 1'b0;
      step(); check("p5_full", outs(), S_FULL);
      soft_reset_0 = 1'b1;
      step(); check("p5_sreset0", outs(), S_FULL);
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b1;
      step(); check("p5_sreset1", outs(), S_DEC);
      soft_reset_1 = 1'b0; fifo_full = 1'b0;

      // Unroutable header stays in decode and causes no write.
      pkt_valid = 1'b1; data_in = 2'b11;
      step(); check("invalid_hdr", outs(), S_DEC);
      pkt_valid = 1'b0;
      step(); check("invalid_hdr_idle", outs(), S_DEC);
`ifdef ROUTER_FSM_STATS_EN
      // Packets 1,2,4 reached the parity check; drops: p4 abort, p5 abort, 1 invalid.
      check("stats_pkt_a", pkt_count, 8'd3);
      check("stats_drop_a", drop_count, 8'd3);
`endif

      // Mid-packet reset returns to decode immediately.
      pkt_valid = 1'b1; data_in = 2'b10;
      step(); step(); check("mid_ld", outs(), S_LD);
      rstn = 1'b0; pkt_valid = 1'b0;
      #1; check("async_reset", outs(), S_DEC);
      step();
      rstn = 1'b1;
      step(); check("post_reset", outs(), S_DEC);

`ifdef ROUTER_FSM_STATS_EN
      check("post_reset_pkt", pkt_count, 8'd0);
      send_pkt(2'b00);
      send_pkt(2'b01);
      send_pkt(2'b10);
      pkt_valid = 1'b1; data_in = 2'b11;
      step();
      pkt_valid = 1'b0;
      step();
      check("stats_pkt3", pkt_count, 8'd3);
      check("stats_drop1", drop_count, 8'd1);
      for (int i = 0; i < 256; i++) send_pkt(2'(i % 3));
      check("stats_pkt_sat", pkt_count, 8'hff);
      check("stats_drop_hold", drop_count, 8'd1);
`else
      send_pkt(2'b00);
`endif
      check("final_state", outs(), S_DEC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
